serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_fulladder.sv | 26 ++
 rtl/serial_adder.sv | 170 +++++++++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder: the
//               control FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int DEFAULT_WIDTH = 8;

    // Control FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fulladder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_fulladder
// Description : Single-bit full adder cell, the only arithmetic element of
//               the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_half;

    // Sum and carry of one bit position.
    always_comb begin
        w_half = a ^ b;
        s      = w_half ^ ci;
        co     = (a & b) | (ci & w_half);
    end

endmodule : serial_adder_fulladder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder with valid/ready handshakes.
//               An operand set is accepted in IDLE, added LSB-first one bit
//               per clock through a single full-adder cell in RUN, and held
//               in DONE until the consumer takes it.
//               Optional feature macro: SERIAL_ADDER_OVF_EN adds the Ovf
//               output (signed overflow: carry into MSB XOR carry out).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    // Counter holds 0..WIDTH without wrapping inside one operation.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-adder outputs for the current bit position.
    logic w_fa_s;
    logic w_fa_co;
    logic w_last_bit;

    // ------------------------------------------------------------------
    // Arithmetic: one full-adder cell, operand LSBs plus running carry.
    // ------------------------------------------------------------------
    serial_adder_fulladder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_last_bit = (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // Register update with asynchronous reset; aborts any operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control; everything holds unless changed.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Capture the operand set; later input changes are ignored.
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                // Sum bit enters at the MSB so bit 0 lands at position 0
                // after WIDTH shifts.
                res_d   = {w_fa_s, res_q[WIDTH-1:1]};
                carry_d = w_fa_co;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (w_last_bit) begin
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB at this point.
                    ovf_d   = carry_q ^ w_fa_co;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                // Result held until the consumer accepts it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded directly from registered state.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign Sum       = res_q;
    assign Cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf       = ovf_q;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
//               Inputs are driven on the falling edge, outputs sampled 1ns
//               after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             Ovf;
`endif

    int n_cmp;
    int n_bad;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one operand set, check acceptance and latency; leaves DUT in DONE.
    // With scramble set, A/B/Cin are changed after every edge during RUN.
    task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic cin,
                            input bit scramble);
        int lat;
        @(negedge clk);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 3 * WIDTH) begin
            if (scramble) begin
                A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(WIDTH));
    endtask

    task automatic check_res(input string tag, input logic [WIDTH-1:0] s, input logic c);
        chk({tag, ".sum"}, 32'(Sum), 32'(s));
        chk({tag, ".cout"}, 32'(Cout), 32'(c));
    endtask

    // Consume the result and confirm return to IDLE on that edge.
    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
        chk({tag, ".ov0"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    bit               seen_ov;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.sum", 32'(Sum), 32'd0);
        chk("rst.cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst.ovf", 32'(Ovf), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic add: 3 + 5 = 8.
        start_op("t1", 8'h03, 8'h05, 1'b0, 1'b0);
        check_res("t1", 8'h08, 1'b0);
        drain("t1");

        // Full carry propagation.
        start_op("t2", 8'hFF, 8'h01, 1'b0, 1'b0);
        check_res("t2", 8'h00, 1'b1);
        drain("t2");

        start_op("t3", 8'hFF, 8'hFF, 1'b1, 1'b0);
        check_res("t3", 8'hFF, 1'b1);
        drain("t3");

        start_op("t4", 8'hA5, 8'h3C, 1'b1, 1'b0);
        check_res("t4", 8'hE2, 1'b0);
        drain("t4");

        // Backpressure: result held, new offers ignored while in DONE.
        start_op("bp", 8'h12, 8'h34, 1'b0, 1'b0);
        held_sum = Sum; held_cout = Cout;
        check_res("bp", 8'h46, 1'b0);
        @(negedge clk);
        A = 8'h77; B = 8'h11; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_sum", 32'(Sum), 32'(held_sum));
            chk("bp.hold_cout", 32'(Cout), 32'(held_cout));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        drain("bp");
        chk("bp.busy", 32'(busy), 32'd0);
        chk("bp.sum_after", 32'(Sum), 32'h46);

        // Reset pulsed mid-RUN after four bits.
        @(negedge clk);
        A = 8'hC3; B = 8'h5A; Cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rr.busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rr.out_valid", 32'(out_valid), 32'd0);
        chk("rr.in_ready", 32'(in_ready), 32'd1);
        chk("rr.sum", 32'(Sum), 32'd0);
        chk("rr.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1'b1;
        end
        chk("rr.no_result", 32'(seen_ov), 32'd0);
        start_op("rr2", 8'h10, 8'h20, 1'b0, 1'b0);
        check_res("rr2", 8'h30, 1'b0);
        drain("rr2");

        // Inputs scrambled during RUN must not affect the result.
        start_op("sc", 8'h9C, 8'h87, 1'b1, 1'b1);
        check_res("sc", 8'h24, 1'b1);
        drain("sc");

`ifdef SERIAL_ADDER_OVF_EN
        start_op("ov1", 8'h7F, 8'h01, 1'b0, 1'b0);
        check_res("ov1", 8'h80, 1'b0);
        chk("ov1.ovf", 32'(Ovf), 32'd1);
        drain("ov1");

        start_op("ov2", 8'h80, 8'h80, 1'b0, 1'b0);
        check_res("ov2", 8'h00, 1'b1);
        chk("ov2.ovf", 32'(Ovf), 32'd1);
        drain("ov2");

        start_op("ov3", 8'h03, 8'h05, 1'b0, 1'b0);
        chk("ov3.ovf", 32'(Ovf), 32'd0);
        drain("ov3");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
